// File: rtl/mem_stage_wbuf_if.sv
// rtl/mem_stage_wbuf_if.sv - memory port bundle between the MEM stage and data memory
interface mem_stage_wbuf_if #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [WORD_SIZE-1:0]  m_wdata;
  logic [WORD_SIZE-1:0]  m_rdata;
  logic                  m_ack;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ack
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ack
  );
endinterface

// File: rtl/mem_stage_wbuf.sv
// rtl/mem_stage_wbuf.sv - MEM stage with EX/MEM register, posted-store buffer and req/ack memory port
module mem_stage_wbuf #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int WBUF_DEPTH   = 4,
  parameter int TARGET_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_mem_write,
  input  logic                    ex_valid,
  input  logic [WORD_SIZE-1:0]    ex_pc,
  input  logic [WORD_SIZE-1:0]    ex_alu_out,
  input  logic [WORD_SIZE-1:0]    ex_store_data,
  input  logic                    ex_mem_read,
  input  logic                    ex_mem_wr,
  input  logic                    ex_reg_write,
  input  logic [1:0]              ex_reg_write_src,
  input  logic [TARGET_WIDTH-1:0] ex_reg_write_target,
  input  logic                    ex_halted,
  output logic                    mem_valid,
  output logic [WORD_SIZE-1:0]    mem_pc,
  output logic [WORD_SIZE-1:0]    mem_alu_out,
  output logic                    mem_reg_write,
  output logic [1:0]              mem_reg_write_src,
  output logic [TARGET_WIDTH-1:0] mem_reg_write_target,
  output logic                    mem_halted,
  output logic [WORD_SIZE-1:0]    mem_load_data,
  output logic                    mem_stall,
  output logic                    drain_done,
  mem_stage_wbuf_if.master        mbus
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // EX/MEM register
  logic                    valid_q, valid_d;
  logic [WORD_SIZE-1:0]    pc_q, pc_d;
  logic [WORD_SIZE-1:0]    alu_q, alu_d;
  logic [WORD_SIZE-1:0]    sdata_q, sdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    rw_q, rw_d;
  logic [1:0]              src_q, src_d;
  logic [TARGET_WIDTH-1:0] tgt_q, tgt_d;
  logic                    halt_q, halt_d;
  // set once the held load/store has finished its memory action, so a held
  // instruction never pushes or loads twice
  logic                    op_done_q, op_done_d;
  logic [WORD_SIZE-1:0]    load_data_q, load_data_d;

  // store buffer, oldest entry at head
  logic [ADDR_WIDTH-1:0]   wb_addr_q [WBUF_DEPTH];
  logic [ADDR_WIDTH-1:0]   wb_addr_d [WBUF_DEPTH];
  logic [WORD_SIZE-1:0]    wb_data_q [WBUF_DEPTH];
  logic [WORD_SIZE-1:0]    wb_data_d [WBUF_DEPTH];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // memory port FSM with registered outputs
  state_t                  state_q, state_d;
  logic                    m_req_q, m_req_d;
  logic                    m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [WORD_SIZE-1:0]    m_wdata_q, m_wdata_d;

  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic                    ld_active, st_active, full;
  logic                    hit, load_pending, push, pop, capture, rd_ack;
  logic [WORD_SIZE-1:0]    hit_data;
  logic [PTR_W-1:0]        scan_idx;

  assign ld_addr   = alu_q[ADDR_WIDTH-1:0];
  assign ld_active = valid_q & rd_q & ~op_done_q;
  assign st_active = valid_q & wr_q & ~op_done_q;
  assign full      = (count_q == CNT_W'(WBUF_DEPTH));

  // youngest-match search: walk oldest to youngest so later matches win
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_addr_q[scan_idx] == ld_addr)) begin
        hit      = 1'b1;
        hit_data = wb_data_q[scan_idx];
      end
    end
  end

  assign load_pending = ld_active & ~hit;
  assign pop          = (state_q == WR) & mbus.m_ack;
  assign rd_ack       = (state_q == RD) & mbus.m_ack;
  assign push         = st_active & (~full | pop);
  assign mem_stall    = (st_active & full) | load_pending;
  assign capture      = ex_mem_write & ~mem_stall;

  // next-state for pipeline register, store buffer and memory port FSM
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    sdata_d     = sdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rw_d        = rw_q;
    src_d       = src_q;
    tgt_d       = tgt_q;
    halt_d      = halt_q;
    op_done_d   = op_done_q;
    load_data_d = load_data_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;

    if (push | (ld_active & hit) | rd_ack) begin
      op_done_d = 1'b1;
    end
    if (ld_active & hit) begin
      load_data_d = hit_data;
    end else if (rd_ack) begin
      load_data_d = mbus.m_rdata;
    end

    if (capture) begin
      valid_d   = ex_valid;
      pc_d      = ex_pc;
      alu_d     = ex_alu_out;
      sdata_d   = ex_store_data;
      rd_d      = ex_mem_read;
      wr_d      = ex_mem_wr;
      rw_d      = ex_reg_write;
      src_d     = ex_reg_write_src;
      tgt_d     = ex_reg_write_target;
      halt_d    = ex_halted;
      op_done_d = 1'b0;
    end

    if (push) begin
      wb_addr_d[tail_q] = alu_q[ADDR_WIDTH-1:0];
      wb_data_d[tail_q] = sdata_q;
      tail_d            = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (load_pending) begin
          state_d   = RD;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = ld_addr;
          m_wdata_d = '0;
        end else if (count_q != '0) begin
          state_d   = WR;
          m_req_d   = 1'b1;
          m_we_d    = 1'b1;
          m_addr_d  = wb_addr_q[head_q];
          m_wdata_d = wb_data_q[head_q];
        end
      end
      RD, WR: begin
        if (mbus.m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
      end
    endcase
  end

  // state registers; reset empties the buffer and abandons any request
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      alu_q       <= '0;
      sdata_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rw_q        <= 1'b0;
      src_q       <= '0;
      tgt_q       <= '0;
      halt_q      <= 1'b0;
      op_done_q   <= 1'b0;
      load_data_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      sdata_q     <= sdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rw_q        <= rw_d;
      src_q       <= src_d;
      tgt_q       <= tgt_d;
      halt_q      <= halt_d;
      op_done_q   <= op_done_d;
      load_data_q <= load_data_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
    end
  end

  assign mem_valid            = valid_q;
  assign mem_pc               = pc_q;
  assign mem_alu_out          = alu_q;
  assign mem_reg_write        = rw_q;
  assign mem_reg_write_src    = src_q;
  assign mem_reg_write_target = tgt_q;
  assign mem_halted           = halt_q;
  assign mem_load_data        = (ld_active & hit) ? hit_data : load_data_q;
  assign drain_done           = (count_q == '0) && (state_q == IDLE);

  assign mbus.m_req   = m_req_q;
  assign mbus.m_we    = m_we_q;
  assign mbus.m_addr  = m_addr_q;
  assign mbus.m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_stage_wbuf.sv
// tb/tb_mem_stage_wbuf.sv - scoreboard bench for the MEM stage and its store buffer
module tb_mem_stage_wbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_write, ex_valid, ex_mem_read, ex_mem_wr, ex_reg_write, ex_halted;
  logic [15:0] ex_pc, ex_alu_out, ex_store_data;
  logic [1:0]  ex_reg_write_src, ex_reg_write_target;
  logic        mem_valid, mem_reg_write, mem_halted, mem_stall, drain_done;
  logic [15:0] mem_pc, mem_alu_out, mem_load_data;
  logic [1:0]  mem_reg_write_src, mem_reg_write_target;

  mem_stage_wbuf_if #(.WORD_SIZE(16), .ADDR_WIDTH(16)) bus ();

  mem_stage_wbuf #(
    .WORD_SIZE(16), .ADDR_WIDTH(16), .WBUF_DEPTH(4), .TARGET_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_wr(ex_mem_wr),
    .ex_reg_write(ex_reg_write), .ex_reg_write_src(ex_reg_write_src),
    .ex_reg_write_target(ex_reg_write_target), .ex_halted(ex_halted),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out),
    .mem_reg_write(mem_reg_write), .mem_reg_write_src(mem_reg_write_src),
    .mem_reg_write_target(mem_reg_write_target), .mem_halted(mem_halted),
    .mem_load_data(mem_load_data), .mem_stall(mem_stall), .drain_done(drain_done),
    .mbus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [15:0] exp_load[$];
  int          checks = 0;
  int          errors = 0;

  logic        force_ack = 1'b0;
  logic        ack_en = 1'b0;
  int          ack_delay = 1;
  logic [15:0] rd_value = '0;
  int          ack_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: acks the outstanding request ack_delay cycles after it appears
  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack) begin
        bus.m_ack = 1'b1;
      end else if (reset || !ack_en) begin
        bus.m_ack = 1'b0;
        ack_cnt   = 0;
      end else if (bus.m_ack) begin
        bus.m_ack = 1'b0;
        ack_cnt   = 0;
      end else if (bus.m_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = rd_value;
        end
      end
    end
  end

  // monitor: checks memory handshakes, request stability and load results
  logic mon_pend = 1'b0;
  req_t mon_held;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_pend = 1'b0;
      end else begin
        if (mon_pend)
          chk("req_stable", {bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata}, {1'b1, mon_held});
        if (bus.m_req && bus.m_ack) begin
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got we=%0b addr=%0h expected no request", bus.m_we, bus.m_addr);
          end else begin
            req_t e;
            e = exp_req.pop_front();
            chk("req_we", bus.m_we, e.we);
            chk("req_addr", bus.m_addr, e.addr);
            if (e.we) chk("req_wdata", bus.m_wdata, e.wdata);
          end
        end
        mon_pend = bus.m_req && !bus.m_ack;
        mon_held = {bus.m_we, bus.m_addr, bus.m_wdata};
        if (mem_valid && mem_read_held() && !mem_stall) begin
          if (exp_load.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL load_unexpected: got %0h expected no load", mem_load_data);
          end else begin
            chk("load_data", mem_load_data, exp_load.pop_front());
          end
        end
      end
    end
  end

  // the held instruction is a load when WB selects memory (src 1) with a write
  function automatic logic mem_read_held();
    return mem_reg_write && (mem_reg_write_src == 2'd1);
  endfunction

  task automatic bubble();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_wr = 1'b0;
    ex_reg_write = 1'b0; ex_reg_write_src = 2'd0;
  endtask

  task automatic set_instr(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input logic [15:0] pc);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_wr = wr; ex_alu_out = addr;
    ex_store_data = data; ex_pc = pc; ex_reg_write = rd;
    ex_reg_write_src = rd ? 2'd1 : 2'd0; ex_reg_write_target = 2'd2;
  endtask

  // called just after a negedge; returns the number of stalled cycles after capture
  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] data, input logic [15:0] pc, output int n);
    set_instr(rd, wr, addr, data, pc);
    for (int k = 0; k < 300 && mem_stall; k++) @(negedge clk);
    @(posedge clk);
    #1 bubble();
    n = 0;
    @(negedge clk);
    chk("capture_pc", mem_pc, pc);
    chk("capture_addr", mem_alu_out, addr);
    while (mem_stall && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && !drain_done; k++) @(negedge clk);
    chk(name, drain_done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    reset = 1'b1; force_ack = 1'b1; ex_mem_write = 1'b1; ex_halted = 1'b0;
    ex_alu_out = 16'h0040; ex_store_data = 16'h1111; ex_reg_write_target = 2'd3;
    set_instr(1'b1, 1'b0, 16'h0040, 16'h1111, 16'h0100);
    ex_halted = 1'b1;

    // T1 reset with ack held high
    repeat (2) @(negedge clk);
    chk("t1_mem_valid", mem_valid, 0);
    chk("t1_mem_pc", mem_pc, 0);
    chk("t1_mem_alu_out", mem_alu_out, 0);
    chk("t1_mem_halted", mem_halted, 0);
    chk("t1_mem_reg_write", {mem_reg_write, mem_reg_write_src, mem_reg_write_target}, 0);
    chk("t1_mem_load_data", mem_load_data, 0);
    chk("t1_mem_stall", mem_stall, 0);
    chk("t1_m_req", {bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata}, 0);
    chk("t1_drain_done", drain_done, 1);
    bubble();
    ex_halted = 1'b0;
    reset = 1'b0; force_ack = 1'b0;
    repeat (2) @(negedge clk);

    // T2 load miss on empty buffer, ack 3 cycles after request
    ack_en = 1'b1; ack_delay = 3; rd_value = 16'hBEEF;
    exp_req.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0000});
    exp_load.push_back(16'hBEEF);
    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0200, n);
    chk("t2_stall_cycles", n, 4);
    chk("t2_load_data", mem_load_data, 16'hBEEF);
    wait_drain("t2_drain");

    // T3 store then load of same address forwards with no stall
    ack_en = 1'b0;
    exp_load.push_back(16'h1234);
    issue(1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0210, n);
    chk("t3_store_stall", n, 0);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0212, n);
    chk("t3_load_stall", n, 0);
    chk("t3_load_data", mem_load_data, 16'h1234);
    @(negedge clk);
    chk("t3_wr_issue", {bus.m_req, bus.m_we, bus.m_addr}, {2'b11, 16'h0010});
    exp_req.push_back('{we: 1'b1, addr: 16'h0010, wdata: 16'h1234});
    ack_delay = 1; ack_en = 1'b1;
    wait_drain("t3_drain");

    // T4 five stores into a four-entry buffer
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back('{we: 1'b1, addr: 16'h0100 + 16'(i), wdata: 16'hA000 + 16'(i)});
      issue(1'b0, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 16'h0300 + 16'(i), n);
      chk("t4_store_no_stall", n, 0);
    end
    exp_req.push_back('{we: 1'b1, addr: 16'h0104, wdata: 16'hA004});
    set_instr(1'b0, 1'b1, 16'h0104, 16'hA004, 16'h0304);
    @(posedge clk);
    #1 bubble();
    @(negedge clk);
    chk("t4_full_stall", mem_stall, 1);
    @(negedge clk);
    chk("t4_full_stall_held", mem_stall, 1);
    @(posedge clk);
    ack_delay = 1; ack_en = 1'b1;
    @(negedge clk);
    chk("t4_stall_in_ack_cycle", mem_stall, 1);
    @(negedge clk);
    chk("t4_stall_drop", mem_stall, 0);
    wait_drain("t4_drain");

    // T5 load miss while a write is in flight
    ack_en = 1'b0;
    exp_req.push_back('{we: 1'b1, addr: 16'h0020, wdata: 16'h5555});
    issue(1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0400, n);
    for (int k = 0; k < 20 && !bus.m_req; k++) @(negedge clk);
    chk("t5_wr_inflight", {bus.m_req, bus.m_we, bus.m_addr}, {2'b11, 16'h0020});
    exp_req.push_back('{we: 1'b0, addr: 16'h0300, wdata: 16'h0000});
    exp_load.push_back(16'h7777);
    rd_value = 16'h7777; ack_delay = 3; ack_en = 1'b1;
    issue(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0402, n);
    chk("t5_stall_cycles", n, 7);
    wait_drain("t5_drain");

    // T6 reset while a read is outstanding with two stores buffered
    ack_en = 1'b0;
    exp_req.push_back('{we: 1'b1, addr: 16'h0030, wdata: 16'h00C0});
    for (int i = 0; i < 3; i++)
      issue(1'b0, 1'b1, 16'h0030 + 16'(i), 16'h00C0 + 16'(i), 16'h0500 + 16'(i), n);
    set_instr(1'b1, 1'b0, 16'h0500, 16'h0000, 16'h0510);
    ack_delay = 2; ack_en = 1'b1;
    @(posedge clk);
    #1 bubble();
    for (int k = 0; k < 50 && !(bus.m_req && !bus.m_we); k++) @(negedge clk);
    chk("t6_in_rd", {bus.m_req, bus.m_we, bus.m_addr}, {2'b10, 16'h0500});
    chk("t6_not_drained", drain_done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_m_req", bus.m_req, 0);
    chk("t6_drain_done", drain_done, 1);
    chk("t6_mem_stall", mem_stall, 0);
    chk("t6_mem_valid", mem_valid, 0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.m_req) seen++;
    end
    chk("t6_no_writes", seen, 0);

    chk("exp_req_empty", exp_req.size(), 0);
    chk("exp_load_empty", exp_load.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
